// File: rtl/text_renderer.sv
// Text-mode pixel generator: 80x25 cells of 16x32 px (8x16 glyphs doubled), reverse video, blinking block cursor.
// Latency: hc/vc to video is 5 px_clk cycles; hsync/vsync/blank are delayed by the same amount.
// Backpressure: none; one fetch per clock, the pipeline never stalls.
module text_renderer #(
  parameter int HBP          = 248,
  parameter int VBP          = 150,
  parameter int COLS         = 80,
  parameter int ROWS         = 25,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        px_clk,
  input  logic        clr,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  input  logic        cursor_en,
  output logic        video,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // stage E decode
  logic        blank_e;
  logic [10:0] hx;
  logic [10:0] vy;
  logic [6:0]  col;
  logic [4:0]  row;
  logic [3:0]  grow_e;
  logic [2:0]  bit_e;
  logic        cur_e;
  logic [10:0] addr_e;

  // pipeline state
  logic [1:0][3:0] grow_d;
  logic [3:0][2:0] bit_d;
  logic [3:0]      cur_d;
  logic [4:0]      blank_d;
  logic [4:0]      hs_d;
  logic [4:0]      vs_d;
  logic            rev_d;
  logic            rev_d2;

  // blink state
  logic            vsync_q;
  logic [CW-1:0]   blink_cnt;
  logic            blink_phase;

  // The lowest offset bit only selects between the two copies of a doubled pixel/line,
  // and vy[10] lies beyond the 25-row field; neither carries information here.
  logic unused_bits;
  assign unused_bits = ^{hx[0], vy[0], vy[10]};

  // Offsets are only formed while visible so blanking never produces a stray address or cursor hit.
  always_comb begin
    blank_e = hblank_in | vblank_in;
    hx      = '0;
    vy      = '0;
    if (!blank_e) begin
      hx = hc - 11'(HBP);
      vy = vc - 11'(VBP);
    end
    col    = hx[10:4];
    row    = vy[9:5];
    grow_e = vy[4:1];
    bit_e  = ~hx[3:1];
    addr_e = {row, 6'b0} + {2'b0, row, 4'b0} + {4'b0, col};
    cur_e  = ~blank_e & cursor_en & blink_phase &
             (cursor_x < 7'(COLS)) & (cursor_y < 5'(ROWS)) &
             (col == cursor_x) & (row == cursor_y);
  end

  // Stage E: issue char buffer address and launch the side-band delay lines.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      char_addr <= '0;
      grow_d    <= '0;
      bit_d     <= '0;
      cur_d     <= '0;
      blank_d   <= '1;
      hs_d      <= '0;
      vs_d      <= '0;
    end else begin
      char_addr <= blank_e ? 11'd0 : addr_e;
      grow_d    <= {grow_d[0], grow_e};
      bit_d     <= {bit_d[2:0], bit_e};
      cur_d     <= {cur_d[2:0], cur_e};
      blank_d   <= {blank_d[3:0], blank_e};
      hs_d      <= {hs_d[3:0], hsync_in};
      vs_d      <= {vs_d[3:0], vsync_in};
    end
  end

  // Stages E+2..E+4: glyph row fetch, reverse flag alignment, final pixel.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      font_addr <= '0;
      rev_d     <= 1'b0;
      rev_d2    <= 1'b0;
      video     <= 1'b0;
    end else begin
      font_addr <= {char_data[6:0], grow_d[1]};
      rev_d     <= char_data[7];
      rev_d2    <= rev_d;
      video     <= blank_d[3] ? 1'b0 : (font_data[bit_d[3]] ^ rev_d2 ^ cur_d[3]);
    end
  end

  // Cursor blink: count vsync rising edges, toggle visibility every BLINK_FRAMES frames.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      vsync_q     <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      vsync_q <= vsync_in;
      if (vsync_in & ~vsync_q) begin
        if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign hsync_out = hs_d[4];
  assign vsync_out = vs_d[4];
  assign blank_out = blank_d[4];

endmodule

// File: tb/tb_text_renderer.sv
module tb_text_renderer;

  localparam int HBP = 248;
  localparam int VBP = 150;

  logic        px_clk = 1'b0;
  logic        clr;
  logic [10:0] hc, vc;
  logic        hblank_in, vblank_in, hsync_in, vsync_in;
  logic [10:0] char_addr, font_addr;
  logic [7:0]  char_data, font_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        cursor_en;
  logic        video, hsync_out, vsync_out, blank_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:2047];
  logic [7:0] rom [0:2047];

  text_renderer #(.HBP(HBP), .VBP(VBP), .COLS(80), .ROWS(25), .BLINK_FRAMES(2)) dut (
    .px_clk(px_clk), .clr(clr), .hc(hc), .vc(vc),
    .hblank_in(hblank_in), .vblank_in(vblank_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .char_addr(char_addr), .char_data(char_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .video(video), .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
  );

  always #5 px_clk = ~px_clk;

  // registered-read char buffer and font ROM models
  always @(posedge px_clk) begin
    char_data <= ram[char_addr];
    font_data <= rom[font_addr];
  end

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic idle();
    hc = '0; vc = '0; hblank_in = 1'b1; vblank_in = 1'b0;
  endtask

  // Sweep one 16-px cell line, then compare each pixel 5 clocks later.
  task automatic run_cell(input logic [10:0] v, input logic [10:0] h0,
                          input logic [15:0] exp, input string nm);
    logic cap [0:20];
    for (int j = 0; j < 21; j++) begin
      if (j < 16) begin
        hc = 11'(h0 + 11'(j)); vc = v; hblank_in = 1'b0; vblank_in = 1'b0;
      end else begin
        idle();
      end
      tick();
      cap[j] = video;
    end
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (cap[j+4] !== exp[15-j]) begin
        errors++;
        $display("FAIL %s px%0d video=%b expected=%b", nm, j, cap[j+4], exp[15-j]);
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; idle();
    hsync_in = 1'b0; vsync_in = 1'b0;
    cursor_en = 1'b0; cursor_x = '0; cursor_y = '0;
    tick(); tick();
    checks++;
    if (video !== 1'b0 || blank_out !== 1'b1 || char_addr !== 11'd0 || font_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_state video=%b blank=%b caddr=%0d faddr=%0d expected 0 1 0 0",
               video, blank_out, char_addr, font_addr);
    end
    clr = 1'b0;
    hc = 11'(HBP + 100); vc = 11'(VBP + 50); hblank_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (char_addr !== 11'd86) begin
      errors++;
      $display("FAIL run_addr char_addr=%0d expected=86", char_addr);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (video !== 1'b0 || blank_out !== 1'b1 || char_addr !== 11'd0 || font_addr !== 11'd0) begin
      errors++;
      $display("FAIL async_clr video=%b blank=%b caddr=%0d faddr=%0d expected 0 1 0 0",
               video, blank_out, char_addr, font_addr);
    end
    tick(); tick();
    hc = 11'(HBP); vc = 11'(VBP);
    clr = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      checks++;
      if (t < 5) begin
        if (video !== 1'b0 || blank_out !== 1'b1) begin
          errors++;
          $display("FAIL release_t%0d video=%b blank=%b expected 0 1", t, video, blank_out);
        end
      end else if (video !== 1'b1 || blank_out !== 1'b0) begin
        errors++;
        $display("FAIL release_t5 video=%b blank=%b expected 1 0", video, blank_out);
      end
    end
    idle(); tick();
  endtask

  task automatic test_address();
    hblank_in = 1'b0;
    hc = 11'(HBP + 16*79); vc = 11'(VBP + 32*24);
    tick();
    checks++;
    if (char_addr !== 11'd1999) begin
      errors++; $display("FAIL addr_max char_addr=%0d expected=1999", char_addr);
    end
    hc = 11'(HBP); vc = 11'(VBP);
    tick();
    checks++;
    if (char_addr !== 11'd0) begin
      errors++; $display("FAIL addr_zero char_addr=%0d expected=0", char_addr);
    end
    hc = 11'(HBP + 80 + 3); vc = 11'(VBP + 96 + 7);
    tick();
    checks++;
    if (char_addr !== 11'd245) begin
      errors++; $display("FAIL addr_53 char_addr=%0d expected=245", char_addr);
    end
    hc = 11'(HBP); vc = 11'(VBP + 10);
    tick(); tick(); tick();
    checks++;
    if (font_addr !== 11'h415) begin
      errors++; $display("FAIL font_addr font_addr=%h expected=415", font_addr);
    end
    hblank_in = 1'b1; vblank_in = 1'b1;
    tick();
    checks++;
    if (char_addr !== 11'd0) begin
      errors++; $display("FAIL addr_blank char_addr=%0d expected=0", char_addr);
    end
    idle(); for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_doubling();
    run_cell(11'(VBP),     11'(HBP), 16'hC003, "dbl_line0");
    run_cell(11'(VBP + 1), 11'(HBP), 16'hC003, "dbl_line1");
    run_cell(11'(VBP + 2), 11'(HBP), 16'h300C, "dbl_line2");
    run_cell(11'(VBP + 3), 11'(HBP), 16'h300C, "dbl_line3");
  endtask

  task automatic test_reverse();
    run_cell(11'(VBP), 11'(HBP + 16), 16'h3FFC, "rev_line0");
    run_cell(11'(VBP + 2), 11'(HBP + 16), 16'hCFF3, "rev_line2");
    hc = 11'(HBP + 16); vc = 11'(VBP); hblank_in = 1'b0; vblank_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (video !== 1'b0 || blank_out !== 1'b1) begin
      errors++; $display("FAIL rev_blank video=%b blank=%b expected 0 1", video, blank_out);
    end
    idle(); for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic pulse_vsync();
    vsync_in = 1'b1; tick(); tick();
    vsync_in = 1'b0; tick(); tick();
  endtask

  task automatic test_cursor();
    cursor_x = 7'd5; cursor_y = 5'd3; cursor_en = 1'b1;
    run_cell(11'(VBP + 96),      11'(HBP + 80), 16'hFFFF, "cur_top");
    run_cell(11'(VBP + 96 + 17), 11'(HBP + 80), 16'hFFFF, "cur_mid");
    run_cell(11'(VBP + 127),     11'(HBP + 80), 16'hFFFF, "cur_bot");
    run_cell(11'(VBP + 96),      11'(HBP + 64), 16'h0000, "cur_left");
    run_cell(11'(VBP + 95),      11'(HBP + 80), 16'h0000, "cur_above");
    cursor_x = 7'd1; cursor_y = 5'd0;
    run_cell(11'(VBP), 11'(HBP + 16), 16'hC003, "cur_on_rev");
    cursor_x = 7'd5; cursor_y = 5'd3;
    pulse_vsync();
    run_cell(11'(VBP + 96), 11'(HBP + 80), 16'hFFFF, "blink_1");
    pulse_vsync();
    run_cell(11'(VBP + 96), 11'(HBP + 80), 16'h0000, "blink_2");
    pulse_vsync();
    run_cell(11'(VBP + 96), 11'(HBP + 80), 16'h0000, "blink_3");
    pulse_vsync();
    run_cell(11'(VBP + 96), 11'(HBP + 80), 16'hFFFF, "blink_4");
    cursor_x = 7'd80;
    run_cell(11'(VBP + 96), 11'(HBP + 80),   16'h0000, "cur_x80_c5");
    run_cell(11'(VBP + 96), 11'(HBP + 1264), 16'h0000, "cur_x80_c79");
    cursor_en = 1'b0;
  endtask

  task automatic test_sync_align();
    logic hs_c [0:23];
    logic vs_c [0:23];
    logic bl_c [0:23];
    for (int j = 0; j < 24; j++) begin
      hsync_in  = (j >= 2 && j < 9);
      vsync_in  = (j >= 4 && j < 7);
      hblank_in = (j >= 10 && j < 14);
      vblank_in = 1'b0;
      hc = 11'(HBP + j); vc = 11'(VBP + 40);
      tick();
      hs_c[j] = hsync_out; vs_c[j] = vsync_out; bl_c[j] = blank_out;
    end
    for (int k = 4; k < 24; k++) begin
      checks++;
      if (hs_c[k] !== 1'((k-4) >= 2 && (k-4) < 9) ||
          vs_c[k] !== 1'((k-4) >= 4 && (k-4) < 7) ||
          bl_c[k] !== 1'((k-4) >= 10 && (k-4) < 14)) begin
        errors++;
        $display("FAIL sync_k%0d hs=%b vs=%b bl=%b expected %b %b %b", k, hs_c[k], vs_c[k], bl_c[k],
                 1'((k-4) >= 2 && (k-4) < 9), 1'((k-4) >= 4 && (k-4) < 7), 1'((k-4) >= 10 && (k-4) < 14));
      end
    end
    hsync_in = 1'b0; vsync_in = 1'b0; idle();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i] = 8'h00;
      rom[i] = 8'h00;
    end
    ram[0]    = 8'h41;
    ram[1]    = 8'hC1;
    ram[1999] = 8'h41;
    for (int r = 0; r < 16; r++) rom[11'h410 + r] = (r % 2 == 0) ? 8'h81 : 8'h42;

    test_reset();
    test_address();
    test_doubling();
    test_reverse();
    test_cursor();
    test_sync_align();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
